// File: rtl/qcldpc_pkg.sv
// qcldpc_pkg: shared FSM state type, codeword defaults and the lift-size masking helper.
package qcldpc_pkg;
  typedef enum logic [1:0] {IDLE, INFO, WAIT_PAR, PAR} state_t;
  localparam int DEF_NUM_INFO_BLKS = 20;
  localparam int DEF_NUM_PAR_BLKS = 4;
  localparam int DEF_NUM_Z = 3;
  localparam int DEF_Z_VALUES [DEF_NUM_Z] = '{27, 54, 81};
  localparam int MASK_W = 1024;
  function automatic logic [MASK_W-1:0] z_mask(input logic [MASK_W-1:0] d, input int unsigned z);
    return (z >= MASK_W) ? d : d & ((MASK_W'(1) << z) - MASK_W'(1));
  endfunction
endpackage

// File: rtl/qcldpc_codeword_serializer.sv
// qcldpc_codeword_serializer: streams info blocks then a buffered parity bundle as one indexed codeword.
module qcldpc_codeword_serializer
  import qcldpc_pkg::*;
#(
  parameter int NUM_Z = DEF_NUM_Z,
  parameter int MAX_Z = 81,
  parameter int NUM_INFO_BLKS = DEF_NUM_INFO_BLKS,
  parameter int NUM_PAR_BLKS = DEF_NUM_PAR_BLKS,
  parameter int Z_VALUES [NUM_Z] = DEF_Z_VALUES,
  localparam int IW = $clog2(NUM_INFO_BLKS + NUM_PAR_BLKS)
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic [NUM_Z-1:0]             req_z,
  input  logic                         info_valid,
  output logic                         info_ready,
  input  logic [MAX_Z-1:0]             info_blk,
  input  logic                         par_valid,
  output logic                         par_ready,
  input  logic [NUM_PAR_BLKS*MAX_Z-1:0] par_blks,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MAX_Z-1:0]             out_blk,
  output logic [IW-1:0]                out_idx,
  output logic                         out_last,
  output logic                         busy,
  output logic                         err_z
);
  localparam int ZW = $clog2(MAX_Z + 1);
  localparam int PW = NUM_PAR_BLKS > 1 ? $clog2(NUM_PAR_BLKS) : 1;
  localparam logic [IW-1:0] LAST_INFO = IW'(NUM_INFO_BLKS - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_INFO_BLKS + NUM_PAR_BLKS - 1);
  state_t state;
  logic [IW-1:0] cnt;
  logic [ZW-1:0] z_lat, z_sel;
  logic [MAX_Z-1:0] par_buf [NUM_PAR_BLKS];
  logic [MAX_Z-1:0] raw_blk, emit_blk;
  logic [PW-1:0] pj;
  logic onehot, out_free, err_cond, err_d, emit;
  assign onehot = $onehot(req_z);
  assign out_free = !out_valid || out_ready;
  assign info_ready = (state == IDLE) ? onehot && out_free : (state == INFO) && out_free;
  assign par_ready = state == WAIT_PAR;
  assign busy = state != IDLE || out_valid;
  assign err_cond = state == IDLE && info_valid && !onehot;
  assign pj = PW'(cnt - IW'(NUM_INFO_BLKS));
  always_comb begin
    z_sel = '0;
    for (int i = 0; i < NUM_Z; i++) if (req_z[i]) z_sel = ZW'(Z_VALUES[i]);
  end
  // Parity block 0 bypasses the buffer so it can leave the cycle after the bundle is accepted.
  assign raw_blk = (state == WAIT_PAR) ? par_blks[MAX_Z-1:0] : (state == PAR) ? par_buf[pj] : info_blk;
  assign emit_blk = MAX_Z'(z_mask(MASK_W'(raw_blk), (state == IDLE) ? 32'(z_sel) : 32'(z_lat)));
  assign emit = (state == WAIT_PAR) ? par_valid && out_free : (state == PAR) ? out_free : info_valid && info_ready;
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      z_lat <= '0;
      par_buf <= '{default: '0};
      out_valid <= 1'b0;
      out_blk <= '0;
      out_idx <= '0;
      out_last <= 1'b0;
      err_z <= 1'b0;
      err_d <= 1'b0;
    end else begin
      err_d <= err_cond;
      err_z <= err_cond && !err_d;
      if (emit) begin
        out_valid <= 1'b1;
        out_blk <= emit_blk;
        out_idx <= (state == IDLE) ? '0 : cnt;
        out_last <= state != IDLE && cnt == LAST_IDX;
        cnt <= (state == IDLE) ? IW'(1) : cnt + IW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (state == IDLE && emit) z_lat <= z_sel;
      if (state == WAIT_PAR && par_valid)
        for (int j = 0; j < NUM_PAR_BLKS; j++) par_buf[j] <= par_blks[j*MAX_Z +: MAX_Z];
      // Leaving PAR on loading the final block lets IDLE accept the next codeword during its handshake.
      unique case (state)
        IDLE:     if (emit) state <= INFO;
        INFO:     if (emit && cnt == LAST_INFO) state <= WAIT_PAR;
        WAIT_PAR: if (par_valid) state <= (emit && cnt == LAST_IDX) ? IDLE : PAR;
        PAR:      if (emit && cnt == LAST_IDX) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qcldpc_codeword_serializer.sv
// tb_qcldpc_codeword_serializer: directed checks of ordering, masking, stalls, errors, reset and back-to-back codewords.
module tb_qcldpc_codeword_serializer;
  localparam int MZ = 81, NP = 4, NI = 20;
  logic CLK = 0, rst_n = 0;
  logic [2:0] req_z = '0;
  logic info_valid = 0, par_valid = 0, out_ready;
  logic info_ready, par_ready, out_valid, out_last, busy, err_z;
  logic [MZ-1:0] info_blk = '0, out_blk;
  logic [NP*MZ-1:0] par_blks = '0;
  logic [4:0] out_idx;
  logic [MZ-1:0] info_pat [NI];
  logic [MZ-1:0] par_pat [NP];
  int cw_z = 27, n_chk = 0, n_pass = 0, cyc = 0, mon_idx = 0, mon_cnt = 0, hs_cyc = 0, gap0 = 0, stall_cnt = 0, m0 = 0;
  bit tog_mode = 0, rdy_set = 1, held = 0;
  logic [MZ-1:0] h_blk;
  logic [4:0] h_idx;
  logic h_last;

  qcldpc_codeword_serializer dut (
    .CLK(CLK), .rst_n(rst_n), .req_z(req_z),
    .info_valid(info_valid), .info_ready(info_ready), .info_blk(info_blk),
    .par_valid(par_valid), .par_ready(par_ready), .par_blks(par_blks),
    .out_valid(out_valid), .out_ready(out_ready), .out_blk(out_blk),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .err_z(err_z)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    #1;
    out_ready = tog_mode ? ~out_ready : rdy_set;
  end

  task automatic chk(input string tag, input logic [MZ-1:0] obs, input logic [MZ-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [MZ-1:0] exp_blk(input int k);
    logic [MZ-1:0] d;
    if (k < NI) d = info_pat[k];
    else d = par_pat[k-NI];
    return d & ((MZ'(1) << cw_z) - MZ'(1));
  endfunction

  // Scoreboard: every handshake must carry the next index and its masked data; stalls must hold.
  always @(negedge CLK) begin
    cyc++;
    if (!rst_n) begin
      mon_idx = 0;
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_blk", out_blk, h_blk);
        chk("hold_idx", out_idx, h_idx);
        chk("hold_last", out_last, h_last);
      end
      held = out_valid && !out_ready;
      if (held) stall_cnt++;
      h_blk = out_blk;
      h_idx = out_idx;
      h_last = out_last;
      if (out_valid && out_ready) begin
        chk("out_idx", out_idx, mon_idx);
        chk("out_blk", out_blk, exp_blk(mon_idx));
        chk("out_last", out_last, mon_idx == 23);
        if (mon_idx == 0) gap0 = cyc - hs_cyc;
        hs_cyc = cyc;
        mon_cnt++;
        mon_idx = (mon_idx == 23) ? 0 : mon_idx + 1;
      end
    end
  end

  task automatic load_par();
    for (int j = 0; j < NP; j++) par_blks[j*MZ +: MZ] = par_pat[j];
  endtask

  task automatic send_info(input int i, input bit par_chk);
    int t = 0;
    info_valid = 1;
    info_blk = info_pat[i];
    @(negedge CLK);
    while (!info_ready && t < 200) begin
      @(negedge CLK);
      t++;
    end
    chk("info_ready", info_ready, 1);
    if (par_chk) chk("par_ready_low", par_ready, 0);
    @(posedge CLK);
    #1;
    info_valid = 0;
    chk("lat1_valid", out_valid, 1);
    chk("lat1_idx", out_idx, i);
  endtask

  task automatic send_par(input bit lat_chk);
    int t = 0;
    par_valid = 1;
    load_par();
    @(negedge CLK);
    while (!par_ready && t < 200) begin
      @(negedge CLK);
      t++;
    end
    chk("par_ready", par_ready, 1);
    @(posedge CLK);
    #1;
    par_valid = 0;
    if (lat_chk) begin
      chk("par_lat_valid", out_valid, 1);
      chk("par_lat_idx", out_idx, 20);
    end
  endtask

  task automatic wait_cnt(input int n);
    int t = 0;
    while (mon_cnt < n && t < 500) begin
      @(negedge CLK);
      t++;
    end
    chk("drain", mon_cnt >= n, 1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_blk", out_blk, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_z", err_z, 0);
    chk("rst_par_ready", par_ready, 0);
    chk("rst_info_ready", info_ready, 0);
    rst_n = 1;
    // Z=27, all-ones data: only bits [26:0] may survive.
    req_z = 3'b001;
    cw_z = 27;
    for (int i = 0; i < NI; i++) info_pat[i] = '1;
    for (int j = 0; j < NP; j++) par_pat[j] = '1;
    for (int i = 0; i < NI; i++) send_info(i, 0);
    send_par(1);
    wait_cnt(24);
    chk("t1_busy", busy, 0);
    chk("t1_valid", out_valid, 0);
    // Z=81 with a toggling sink.
    req_z = 3'b100;
    cw_z = 81;
    for (int i = 0; i < NI; i++) info_pat[i] = MZ'({$urandom(), $urandom(), $urandom()});
    for (int j = 0; j < NP; j++) par_pat[j] = MZ'({11{8'hA5}} << j);
    tog_mode = 1;
    for (int i = 0; i < NI; i++) send_info(i, 0);
    send_par(0);
    wait_cnt(48);
    chk("t2_stalls", stall_cnt > 0, 1);
    tog_mode = 0;
    repeat (2) @(posedge CLK);
    #1;
    // Invalid lift select in IDLE.
    req_z = 3'b011;
    info_valid = 1;
    @(negedge CLK);
    chk("err_info_ready", info_ready, 0);
    chk("err_busy", busy, 0);
    chk("err_pre", err_z, 0);
    @(posedge CLK);
    #1;
    chk("err_pulse", err_z, 1);
    @(posedge CLK);
    #1;
    chk("err_once", err_z, 0);
    chk("err_no_out", out_valid, 0);
    chk("err_idle", busy, 0);
    info_valid = 0;
    chk("err_cnt", mon_cnt, 48);
    // Parity offered early, Z=54.
    req_z = 3'b010;
    cw_z = 54;
    for (int i = 0; i < NI; i++) info_pat[i] = MZ'({$urandom(), $urandom(), $urandom()});
    for (int j = 0; j < NP; j++) par_pat[j] = MZ'({$urandom(), $urandom(), $urandom()});
    load_par();
    par_valid = 1;
    for (int i = 0; i < NI; i++) send_info(i, 1);
    @(negedge CLK);
    chk("early_par_ready", par_ready, 1);
    @(posedge CLK);
    #1;
    par_valid = 0;
    chk("early_par_valid", out_valid, 1);
    chk("early_par_idx", out_idx, 20);
    @(negedge CLK);
    chk("early_par_done", par_ready, 0);
    wait_cnt(72);
    // Asynchronous reset mid-codeword.
    req_z = 3'b001;
    cw_z = 27;
    for (int i = 0; i < 10; i++) send_info(i, 0);
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_blk", out_blk, 0);
    chk("arst_idx", out_idx, 0);
    chk("arst_last", out_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err_z, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    rst_n = 1;
    m0 = mon_cnt;
    repeat (5) @(posedge CLK);
    #1;
    chk("post_rst_quiet", out_valid, 0);
    chk("post_rst_cnt", mon_cnt, m0);
    for (int i = 0; i < NI; i++) send_info(i, 0);
    send_par(1);
    wait_cnt(m0 + 24);
    // Two codewords back-to-back.
    req_z = 3'b010;
    cw_z = 54;
    for (int i = 0; i < NI; i++) send_info(i, 0);
    send_par(1);
    for (int i = 0; i < NI; i++) send_info(i, 0);
    send_par(1);
    wait_cnt(m0 + 72);
    chk("b2b_gap", gap0, 1);
    chk("b2b_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/qcldpc_codeword_serializer.md
QCLDPC_CODEWORD_SERIALIZER -- requirements
Module: qcldpc_codeword_serializer

Interface
REQ-001 SHALL have parameter NUM_Z, default 3: number of supported lift sizes.
REQ-002 SHALL have parameter MAX_Z, default 81: widest block, in bits.
REQ-003 SHALL have parameter NUM_INFO_BLKS, default 20: info blocks per codeword.
REQ-004 SHALL have parameter NUM_PAR_BLKS, default 4: parity blocks per codeword.
REQ-005 SHALL have parameter Z_VALUES[NUM_Z], default {27,54,81}: lift size selected by each req_z bit.
REQ-006 SHALL have port CLK, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port req_z, input, NUM_Z: one-hot lift select, sampled on the first info accept of a codeword.
REQ-009 SHALL have port info_valid / info_ready, input / output, 1 each: info block handshake.
REQ-010 SHALL have port info_blk, input, MAX_Z: info block, right-aligned in bits [Z-1:0].
REQ-011 SHALL have port par_valid / par_ready, input / output, 1 each: parity bundle handshake.
REQ-012 SHALL have port par_blks, input, NUM_PAR_BLKS*MAX_Z: flattened bundle; parity j in [j*MAX_Z +: MAX_Z].
REQ-013 SHALL have port out_valid / out_ready, output / input, 1 each: codeword block handshake.
REQ-014 SHALL have port out_blk, output, MAX_Z: outgoing block, bits [MAX_Z-1:Z] forced to 0.
REQ-015 SHALL have port out_idx, output, $clog2(NUM_INFO_BLKS+NUM_PAR_BLKS): block index 0..23.
REQ-016 SHALL have port out_last, output, 1: high with the final block (idx 23).
REQ-017 SHALL have ports busy and err_z, outputs, 1 each: codeword in progress; one-cycle invalid req_z pulse.

Function
REQ-018 SHALL implement FSM states IDLE, INFO, WAIT_PAR, PAR.
REQ-019 In IDLE, info_ready SHALL be high only if req_z is one-hot and the output register is free (!out_valid || out_ready).
REQ-020 IDLE with info_valid high and req_z not one-hot SHALL pulse err_z for 1 cycle, SHALL accept nothing, and SHALL remain in IDLE.
REQ-021 The first accept in IDLE SHALL latch the selected Z, reset the counter to 1, and go to INFO.
REQ-022 In INFO, info_ready SHALL be (!out_valid || out_ready); req_z SHALL be ignored.
REQ-023 Each accepted info block SHALL appear on out_blk with out_valid the next cycle (latency 1), masked to Z bits.
REQ-024 After the NUM_INFO_BLKS-th accept, the FSM SHALL go to WAIT_PAR.
REQ-025 In WAIT_PAR, par_ready SHALL be 1; elsewhere it SHALL be 0.
REQ-026 A parity accept SHALL capture all NUM_PAR_BLKS blocks into an internal buffer and go to PAR.
REQ-027 In PAR, parity blocks SHALL be emitted in order j=0..3, one per out handshake, back-to-back when out_ready is held high.
REQ-028 The first parity block SHALL appear the cycle after the parity accept, provided the info block 19 output has drained.
REQ-029 out_idx SHALL equal 0..19 for info blocks and 20..23 for parity blocks.
REQ-030 out_last SHALL be asserted only with idx 23; its handshake SHALL return the FSM to IDLE.
REQ-031 While out_valid is high and out_ready is low, out_blk, out_idx and out_last SHALL hold stable.
REQ-032 busy SHALL be high in every state except IDLE and whenever out_valid is high.
REQ-033 In IDLE, the FSM SHALL accept a new codeword in the same cycle that the idx-23 handshake completes.

Reset
REQ-034 rst_n low SHALL immediately clear out_valid, out_blk, out_idx, out_last, err_z, busy, the counter, the parity buffer and the latched Z.
REQ-035 rst_n low SHALL force the FSM to IDLE.
REQ-036 A reset asserted mid-codeword SHALL discard the partial codeword, and no block SHALL be emitted afterwards until a new codeword starts.

Structure
REQ-037 Package qcldpc_pkg SHALL hold the FSM state enum, NUM_INFO_BLKS/NUM_PAR_BLKS defaults, and the Z_VALUES default array.
REQ-038 The block SHALL have no sub-module; Z masking SHALL be an automatic function in qcldpc_pkg.

Verification
REQ-039 Bench SHALL run: req_z=3'b001, 20 info blocks of all-ones, one parity bundle, out_ready=1 -> 24 blocks, idx 0..23; each block has bits [26:0] set and [80:27] zero; out_last only at 23.
REQ-040 Bench SHALL run: req_z=3'b100 with parity blocks 0xA5-patterned, out_ready toggling 1/0 every cycle -> no data loss or duplication; outputs stable while stalled.
REQ-041 Bench SHALL run: req_z=3'b011 in IDLE with info_valid=1 -> err_z pulses once, info_ready=0, busy=0.
REQ-042 Bench SHALL run: par_valid held high during INFO -> par_ready=0 until 20 info accepts are done, then bundle accepted in 1 cycle.
REQ-043 Bench SHALL run: rst_n pulsed low after 10 info accepts -> all outputs 0 asynchronously; next codeword restarts at idx 0.
REQ-044 Bench SHALL run: two codewords back-to-back with out_ready=1 -> second codeword idx 0 follows idx 23 with no idle cycle.
